// File: rtl/nf_uart_pkg.sv
// Shared types for the UART receive path: capture FSM encoding and buffer sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nf_uart_pkg;

  // Capture handshake with nf_uart_receiver: one write per valid episode.
  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ACK  = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_t;

  // Default FIFO depth is 2**DEPTH_LOG2_DEF = 16 bytes.
  localparam int DEPTH_LOG2_DEF = 4;

endpackage

// File: rtl/nf_uart_fifo_mem.sv
// Byte storage for the receive FIFO: 2**DEPTH_LOG2 x 8 register array.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none, the caller only writes when a slot is free.
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
// Contents are deliberately not reset; occupancy is tracked by the caller.
module nf_uart_fifo_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nf_uart_rx_buffer.sv
// Receive buffer behind nf_uart_receiver: acks each valid byte and queues it for the bus.
// Latency: byte stored on the edge rx_valid is seen in IDLE; visible on rd_data/count next cycle.
// Backpressure: never stalls the receiver; a byte arriving while full is dropped and flags overflow.
// Ports: clk/resetn; rx_data/rx_valid in, rx_val_set ack out; rd_req pop in, rd_data head
// (show-ahead, 0 when empty); empty/full/count status; overflow sticky with ovf_clr; fifo_clr flush.
module nf_uart_rx_buffer
  import nf_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_val_set,
  input  logic                  rd_req,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  input  logic                  fifo_clr
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  cap_state_t state_q, state_d;
  logic       capture;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  pop_ok, wr_ok, drop, mem_we;
  logic [7:0]            head_dat;

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CAP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    rx_val_set = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (rx_valid) begin
          capture = 1'b1;
          state_d = CAP_ACK;
        end
      end
      CAP_ACK: begin
        rx_val_set = 1'b1;
        state_d    = CAP_WAIT;
      end
      CAP_WAIT: begin
        // Hold off until the receiver drops valid so a byte is written only once.
        if (!rx_valid) begin
          state_d = CAP_IDLE;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // ---------------- FIFO control ----------------
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_CNT);
  assign pop_ok = rd_req && !empty;
  // A pop on a full FIFO frees a slot on the same edge, so the write still fits.
  assign wr_ok  = capture && (!full || pop_ok);
  assign drop   = capture && full && !pop_ok;
  // Flush discards any byte captured in the same cycle.
  assign mem_we = wr_ok && !fifo_clr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Set beats clear when both happen together; a flush leaves the flag alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  nf_uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (rx_data),
    .raddr (rd_ptr_q),
    .rdata (head_dat)
  );

  // Stale memory contents must not leak out while the queue is empty.
  assign rd_data  = empty ? 8'h00 : head_dat;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
